// File: rtl/lt24_lcd_bus_receiver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lt24_lcd_bus_receiver
//
// Receive side of the LT24 8080-style LCD write bus (ILI9341 subset).
// Watches the bus driven by the LT24 controller, decodes the column/page
// address set commands (CASET/PASET) and memory writes (RAMWR and
// RAMWR-continue), and emits one pixel strobe per memory-write data word,
// tagged with the window-addressed (x,y) it lands on.
//
// Ports
//   clk_clk      in   1        system clock; all bus inputs are synchronous to it
//   reset_reset  in   1        asynchronous, active-high reset
//   lcd_cs_n     in   1        chip select, active low
//   lcd_rs       in   1        0 = command word, 1 = data word
//   lcd_wr_n     in   1        write strobe; the word is taken on its rising edge
//   lcd_rd_n     in   1        read strobe; a write seen while it is low is dropped
//   lcd_data     in   16       bus data; commands and parameters use [7:0]
//   lcd_reset_n  in   1        panel hardware reset, active low, synchronous
//   pix_valid    out  1        one-cycle pixel-write strobe
//   pix_x        out  COORD_W  pixel column
//   pix_y        out  COORD_W  pixel row
//   pix_rgb      out  16       RGB565 pixel data
//   pix_oob      out  1        one-cycle pulse: write landed outside the panel
//   display_on   out  1        set by DISPON (0x29), cleared by DISPOFF (0x28)
//   sleep_out    out  1        set by SLPOUT (0x11), cleared by SLPIN (0x10)
// ---------------------------------------------------------------------------
module lt24_lcd_bus_receiver #(
    parameter int H_RES   = 240,
    parameter int V_RES   = 320,
    parameter int COORD_W = 9
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               lcd_cs_n,
    input  logic               lcd_rs,
    input  logic               lcd_wr_n,
    input  logic               lcd_rd_n,
    input  logic [15:0]        lcd_data,
    input  logic               lcd_reset_n,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [15:0]        pix_rgb,
    output logic               pix_oob,
    output logic               display_on,
    output logic               sleep_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR
    } state_t;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

    localparam logic [15:0] X_LIMIT = 16'(H_RES);
    localparam logic [15:0] Y_LIMIT = 16'(V_RES);
    localparam logic [15:0] X_LAST  = 16'(H_RES - 1);
    localparam logic [15:0] Y_LAST  = 16'(V_RES - 1);

    // Parameter index saturates here: anything after the 4th parameter is
    // swallowed until the next command.
    localparam logic [2:0] PARAM_DONE = 3'd4;

    // -----------------------------------------------------------------------
    // Input stage: every bus line registered once (stage A); wr_n registered
    // a second time (stage B) so a rising edge shows up as B=0, A=1.
    // -----------------------------------------------------------------------
    logic        a_cs_n;
    logic        a_rs;
    logic        a_wr_n;
    logic        a_rd_n;
    logic [15:0] a_data;
    logic        b_wr_n;

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // the pre-edge value of the others; blocking here would let stage B see
    // the value stage A is taking on the same edge and the edge would vanish.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            a_cs_n <= 1'b1;
            a_rs   <= 1'b0;
            a_wr_n <= 1'b1;
            a_rd_n <= 1'b1;
            a_data <= '0;
            b_wr_n <= 1'b1;
        end else begin
            a_cs_n <= lcd_cs_n;
            a_rs   <= lcd_rs;
            a_wr_n <= lcd_wr_n;
            a_rd_n <= lcd_rd_n;
            a_data <= lcd_data;
            b_wr_n <= a_wr_n;
        end
    end

    logic write_event;
    logic cmd_event;
    logic data_event;

    assign write_event = !b_wr_n && a_wr_n && !a_cs_n && a_rd_n;
    assign cmd_event   = write_event && !a_rs;
    assign data_event  = write_event &&  a_rs;

    // -----------------------------------------------------------------------
    // Decode state
    // -----------------------------------------------------------------------
    state_t      state;
    logic [2:0]  param_idx;
    logic [7:0]  start_hi;
    logic [7:0]  start_lo;
    logic [7:0]  end_hi;
    logic [15:0] sc;
    logic [15:0] ec;
    logic [15:0] sp;
    logic [15:0] ep;
    logic [15:0] x;
    logic [15:0] y;

    logic [15:0] next_x;
    logic [15:0] next_y;
    logic        in_range;
    logic [15:0] win_start;
    logic [15:0] win_end_raw;
    logic [15:0] win_end;

    // NOTE: every signal driven here gets a default at the top of the block,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        next_x = x + 16'd1;
        next_y = y;
        if (x == ec) begin
            next_x = sc;
            next_y = (y == ep) ? sp : y + 16'd1;
        end

        in_range = (x < X_LIMIT) && (y < Y_LIMIT);

        // The 4th parameter is still on the bus when it is applied, so the
        // end value is assembled from the live low byte.
        win_start   = {start_hi, start_lo};
        win_end_raw = {end_hi, a_data[7:0]};
        win_end     = (win_start > win_end_raw) ? win_start : win_end_raw;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state      <= ST_IDLE;
            param_idx  <= '0;
            start_hi   <= '0;
            start_lo   <= '0;
            end_hi     <= '0;
            sc         <= '0;
            ec         <= X_LAST;
            sp         <= '0;
            ep         <= Y_LAST;
            x          <= '0;
            y          <= '0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_rgb    <= '0;
            pix_oob    <= 1'b0;
            display_on <= 1'b0;
            sleep_out  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            pix_valid <= 1'b0;
            pix_oob   <= 1'b0;

            if (!lcd_reset_n) begin
                // Panel reset wins over any write event in the same cycle.
                state      <= ST_IDLE;
                param_idx  <= '0;
                start_hi   <= '0;
                start_lo   <= '0;
                end_hi     <= '0;
                sc         <= '0;
                ec         <= X_LAST;
                sp         <= '0;
                ep         <= Y_LAST;
                x          <= '0;
                y          <= '0;
                pix_x      <= '0;
                pix_y      <= '0;
                pix_rgb    <= '0;
                display_on <= 1'b0;
                sleep_out  <= 1'b0;
            end else if (cmd_event) begin
                // Any command abandons a partially received parameter list.
                param_idx <= '0;
                case (a_data[7:0])
                    CMD_CASET:  state <= ST_CASET;
                    CMD_PASET:  state <= ST_PASET;
                    CMD_RAMWR: begin
                        state <= ST_RAMWR;
                        x     <= sc;
                        y     <= sp;
                    end
                    CMD_RAMWRC: state <= ST_RAMWR;
                    CMD_SWRESET: begin
                        state      <= ST_IDLE;
                        sc         <= '0;
                        ec         <= X_LAST;
                        sp         <= '0;
                        ep         <= Y_LAST;
                        display_on <= 1'b0;
                        sleep_out  <= 1'b0;
                    end
                    CMD_SLPIN: begin
                        state     <= ST_IDLE;
                        sleep_out <= 1'b0;
                    end
                    CMD_SLPOUT: begin
                        state     <= ST_IDLE;
                        sleep_out <= 1'b1;
                    end
                    CMD_DISPOFF: begin
                        state      <= ST_IDLE;
                        display_on <= 1'b0;
                    end
                    CMD_DISPON: begin
                        state      <= ST_IDLE;
                        display_on <= 1'b1;
                    end
                    default:    state <= ST_IDLE;
                endcase
            end else if (data_event) begin
                case (state)
                    ST_CASET, ST_PASET: begin
                        case (param_idx)
                            3'd0: start_hi <= a_data[7:0];
                            3'd1: start_lo <= a_data[7:0];
                            3'd2: end_hi   <= a_data[7:0];
                            3'd3: begin
                                // Window only changes once the full list is in.
                                if (state == ST_CASET) begin
                                    sc <= win_start;
                                    ec <= win_end;
                                end else begin
                                    sp <= win_start;
                                    ep <= win_end;
                                end
                            end
                            default: ;
                        endcase
                        if (param_idx != PARAM_DONE) begin
                            param_idx <= param_idx + 3'd1;
                        end
                    end
                    ST_RAMWR: begin
                        if (in_range) begin
                            pix_valid <= 1'b1;
                            pix_x     <= x[COORD_W-1:0];
                            pix_y     <= y[COORD_W-1:0];
                            pix_rgb   <= a_data;
                        end else begin
                            pix_oob <= 1'b1;
                        end
                        // The pointer walks the window even over off-panel
                        // words so later pixels keep their addresses.
                        x <= next_x;
                        y <= next_y;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lt24_lcd_bus_receiver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_lt24_lcd_bus_receiver
//
// Self-checking bench for lt24_lcd_bus_receiver: reset state, a table of
// directed bus words with their expected pixel/flag responses, hand-written
// reset sequences, and randomized back-to-back bursts checked against a
// behavioural model of the command set.
// ---------------------------------------------------------------------------
module tb_lt24_lcd_bus_receiver;

    localparam int COORD_W = 9;

    logic               clk = 1'b0;
    logic               rst;
    logic               cs_n;
    logic               rs;
    logic               wr_n;
    logic               rd_n;
    logic [15:0]        data;
    logic               lcd_rst_n;
    logic               pix_valid;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic [15:0]        pix_rgb;
    logic               pix_oob;
    logic               display_on;
    logic               sleep_out;

    lt24_lcd_bus_receiver #(
        .H_RES  (240),
        .V_RES  (320),
        .COORD_W(COORD_W)
    ) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .lcd_cs_n   (cs_n),
        .lcd_rs     (rs),
        .lcd_wr_n   (wr_n),
        .lcd_rd_n   (rd_n),
        .lcd_data   (data),
        .lcd_reset_n(lcd_rst_n),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_rgb    (pix_rgb),
        .pix_oob    (pix_oob),
        .display_on (display_on),
        .sleep_out  (sleep_out)
    );

    always #5 clk = ~clk;

    // Observed / expected pixel events. An off-panel event carries no data.
    typedef struct packed {
        logic        oob;
        logic [8:0]  x;
        logic [8:0]  y;
        logic [15:0] rgb;
    } ev_t;

    // One directed bus word plus what must follow it.
    // kind: 0 = no pixel event, 1 = pix_valid at (ex,ey) with rgb=data, 2 = pix_oob.
    typedef struct {
        logic        rs;
        logic [15:0] data;
        logic        cs_n;
        logic        rd_n;
        int          kind;
        int          ex;
        int          ey;
        logic        sleep;
        logic        disp;
    } vec_t;

    ev_t  obs_q[$];
    ev_t  exp_q[$];
    vec_t tbl[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    logic tf_sleep = 1'b0;
    logic tf_disp  = 1'b0;

    always @(negedge clk) begin
        if (pix_valid) obs_q.push_back(ev_t'{oob: 1'b0, x: pix_x, y: pix_y, rgb: pix_rgb});
        if (pix_oob)   obs_q.push_back(ev_t'{oob: 1'b1, x: 9'd0, y: 9'd0, rgb: 16'd0});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One bus write: wr_n low for one clock, high for one clock.
    task automatic write_word(input logic w_rs, input logic [15:0] w_data,
                              input logic w_cs_n, input logic w_rd_n);
        @(negedge clk);
        cs_n = w_cs_n;
        rs   = w_rs;
        rd_n = w_rd_n;
        data = w_data;
        wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v_rs, input logic [15:0] d, input logic v_cs,
                                input logic v_rd, input int kind, input int ex, input int ey,
                                input logic sl, input logic dp);
        vec_t v;
        v.rs = v_rs; v.data = d; v.cs_n = v_cs; v.rd_n = v_rd;
        v.kind = kind; v.ex = ex; v.ey = ey; v.sleep = sl; v.disp = dp;
        return v;
    endfunction

    function automatic void tc(input logic [15:0] d);
        tbl.push_back(mk(1'b0, d, 1'b0, 1'b1, 0, 0, 0, tf_sleep, tf_disp));
    endfunction
    function automatic void td(input logic [15:0] d);
        tbl.push_back(mk(1'b1, d, 1'b0, 1'b1, 0, 0, 0, tf_sleep, tf_disp));
    endfunction
    function automatic void tp(input logic [15:0] d, input int px, input int py);
        tbl.push_back(mk(1'b1, d, 1'b0, 1'b1, 1, px, py, tf_sleep, tf_disp));
    endfunction
    function automatic void to(input logic [15:0] d);
        tbl.push_back(mk(1'b1, d, 1'b0, 1'b1, 2, 0, 0, tf_sleep, tf_disp));
    endfunction
    function automatic void tx(input logic v_rs, input logic [15:0] d, input logic v_cs, input logic v_rd);
        tbl.push_back(mk(v_rs, d, v_cs, v_rd, 0, 0, 0, tf_sleep, tf_disp));
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        ev_t e;
        obs_q.delete();
        write_word(v.rs, v.data, v.cs_n, v.rd_n);
        settle();
        if (v.kind == 0) begin
            check({tag, "_no_event"}, obs_q.size(), 0);
        end else begin
            check({tag, "_event_count"}, obs_q.size(), 1);
            if (obs_q.size() > 0) begin
                e = obs_q[0];
                check({tag, "_oob"}, e.oob, (v.kind == 2) ? 1 : 0);
                if (v.kind == 1) begin
                    check({tag, "_x"}, e.x, v.ex);
                    check({tag, "_y"}, e.y, v.ey);
                    check({tag, "_rgb"}, e.rgb, v.data);
                end
            end
        end
        check({tag, "_sleep_out"}, sleep_out, v.sleep);
        check({tag, "_display_on"}, display_on, v.disp);
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: window registers, a pointer, a parameter list.
    // m_state: 0 idle, 1 column-address params, 2 page-address params, 3 memory write.
    // ---------------------------------------------------------------------
    int         m_sc, m_ec, m_sp, m_ep, m_x, m_y, m_state;
    logic       m_sleep, m_disp;
    logic [7:0] m_par[$];

    function automatic void m_reset();
        m_sc = 0; m_ec = 239; m_sp = 0; m_ep = 319;
        m_x = 0; m_y = 0; m_state = 0;
        m_sleep = 1'b0; m_disp = 1'b0;
        m_par.delete();
    endfunction

    function automatic void m_write(input logic w_rs, input logic [15:0] d,
                                    input logic w_cs_n, input logic w_rd_n);
        int s;
        int e;
        if (w_cs_n || !w_rd_n) return;
        if (!w_rs) begin
            m_par.delete();
            case (d[7:0])
                8'h2A: m_state = 1;
                8'h2B: m_state = 2;
                8'h2C: begin m_state = 3; m_x = m_sc; m_y = m_sp; end
                8'h3C: m_state = 3;
                8'h01: begin
                    m_sc = 0; m_ec = 239; m_sp = 0; m_ep = 319;
                    m_sleep = 1'b0; m_disp = 1'b0; m_state = 0;
                end
                8'h10: begin m_sleep = 1'b0; m_state = 0; end
                8'h11: begin m_sleep = 1'b1; m_state = 0; end
                8'h28: begin m_disp = 1'b0; m_state = 0; end
                8'h29: begin m_disp = 1'b1; m_state = 0; end
                default: m_state = 0;
            endcase
        end else if (m_state == 1 || m_state == 2) begin
            if (m_par.size() < 4) begin
                m_par.push_back(d[7:0]);
                if (m_par.size() == 4) begin
                    s = m_par[0] * 256 + m_par[1];
                    e = m_par[2] * 256 + m_par[3];
                    if (s > e) e = s;
                    if (m_state == 1) begin m_sc = s; m_ec = e; end
                    else begin m_sp = s; m_ep = e; end
                end
            end
        end else if (m_state == 3) begin
            if (m_x < 240 && m_y < 320)
                exp_q.push_back(ev_t'{oob: 1'b0, x: 9'(m_x), y: 9'(m_y), rgb: d});
            else
                exp_q.push_back(ev_t'{oob: 1'b1, x: 9'd0, y: 9'd0, rgb: 16'd0});
            if (m_x == m_ec) begin
                m_x = m_sc;
                m_y = (m_y == m_ep) ? m_sp : (m_y + 1) % 65536;
            end else begin
                m_x = (m_x + 1) % 65536;
            end
        end
    endfunction

    logic [7:0]  cmd_list [10];
    logic        g_rs, g_cs, g_rd;
    logic [15:0] g_data;
    logic [7:0]  g_code;
    int          g_r;
    int          n_cmp;

    initial begin
        rst = 1'b1; lcd_rst_n = 1'b1; cs_n = 1'b1; rs = 1'b0;
        wr_n = 1'b1; rd_n = 1'b1; data = '0;
        cmd_list = '{8'h2A, 8'h2B, 8'h2C, 8'h3C, 8'h01, 8'h10, 8'h11, 8'h28, 8'h29, 8'h00};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_pix_valid", pix_valid, 0);
        check("reset_pix_oob", pix_oob, 0);
        check("reset_pix_x", pix_x, 0);
        check("reset_pix_y", pix_y, 0);
        check("reset_pix_rgb", pix_rgb, 0);
        check("reset_display_on", display_on, 0);
        check("reset_sleep_out", sleep_out, 0);

        // ---------------- directed table ----------------
        // First pixel after reset lands at the default window origin.
        tc(16'h002C); tp(16'hF800, 0, 0);
        // Window 10..12 x 5..6, wraps back to the origin; param upper bytes are junk.
        tc(16'h002A); td(16'hFF00); td(16'h000A); td(16'hAB00); td(16'h000C);
        tc(16'h002B); td(16'h0000); td(16'h0005); td(16'h0000); td(16'h0006);
        tc(16'h002C);
        tp(16'h07E0, 10, 5); tp(16'h07E1, 11, 5); tp(16'h07E2, 12, 5);
        tp(16'h07E3, 10, 6); tp(16'h07E4, 11, 6); tp(16'h07E5, 12, 6);
        tp(16'h07E6, 10, 5);
        // Partial parameter list is discarded; continue-write keeps the pointer.
        tc(16'h002A); td(16'h0000); td(16'h0020);
        tc(16'h002C); tp(16'h001F, 10, 5);
        tc(16'h003C); tp(16'h001E, 11, 5);
        // Column window straddling the right panel edge.
        tc(16'h002A); td(16'h0000); td(16'h00EF); td(16'h0000); td(16'h00F1);
        tc(16'h002B); td(16'h0000); td(16'h0000); td(16'h0000); td(16'h0000);
        tc(16'h002C); tp(16'h1234, 239, 0); to(16'h5678); to(16'h9ABC);
        // start > end collapses the window to a single column.
        tc(16'h002A); td(16'h0000); td(16'h0005); td(16'h0000); td(16'h0002);
        tc(16'h002B); td(16'h0000); td(16'h0000); td(16'h0000); td(16'h0001);
        tc(16'h002C); tp(16'hA001, 5, 0); tp(16'hA002, 5, 1); tp(16'hA003, 5, 0);
        // Parameters past the 4th are ignored.
        tc(16'h002A); td(16'h0000); td(16'h0001); td(16'h0000); td(16'h0002);
        td(16'h0000); td(16'h0009);
        tc(16'h002C); tp(16'hB001, 1, 0); tp(16'hB002, 2, 0); tp(16'hB003, 1, 1);
        // Flags, idle data, reads-in-progress and deselected writes.
        tf_sleep = 1'b1; tc(16'h0011);
        tf_disp  = 1'b1; tc(16'h0029);
        td(16'h1234);
        tx(1'b0, 16'h0028, 1'b0, 1'b0);
        tx(1'b0, 16'h0010, 1'b1, 1'b1);
        tf_sleep = 1'b0; tc(16'h0010);
        tf_sleep = 1'b1; tc(16'h0011);
        tc(16'hFF2C);
        tx(1'b1, 16'hC001, 1'b0, 1'b0);
        tx(1'b1, 16'hC002, 1'b1, 1'b1);
        tp(16'hC003, 1, 0);
        tf_disp = 1'b0; tc(16'h0028);
        tf_disp = 1'b1; tc(16'h0029);
        tf_sleep = 1'b0; tf_disp = 1'b0; tc(16'h0001);
        tc(16'h002C); tp(16'hD001, 0, 0); tp(16'hD002, 1, 0);

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // ---------------- panel reset during a memory write ----------------
        run_vec(mk(1'b0, 16'h0029, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1), "lrst_dispon");
        run_vec(mk(1'b0, 16'h002A, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1), "lrst_caset");
        run_vec(mk(1'b1, 16'h0000, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1), "lrst_p0");
        run_vec(mk(1'b1, 16'h0003, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1), "lrst_p1");
        run_vec(mk(1'b1, 16'h0000, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1), "lrst_p2");
        run_vec(mk(1'b1, 16'h0004, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1), "lrst_p3");
        run_vec(mk(1'b0, 16'h002C, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1), "lrst_ramwr");
        run_vec(mk(1'b1, 16'hE001, 1'b0, 1'b1, 1, 3, 0, 1'b0, 1'b1), "lrst_w1");
        run_vec(mk(1'b1, 16'hE002, 1'b0, 1'b1, 1, 4, 0, 1'b0, 1'b1), "lrst_w2");
        obs_q.delete();
        @(negedge clk);
        lcd_rst_n = 1'b0;
        write_word(1'b1, 16'hE003, 1'b0, 1'b1);
        write_word(1'b0, 16'h0029, 1'b0, 1'b1);
        settle();
        check("lrst_w3_dropped", obs_q.size(), 0);
        check("lrst_display_cleared", display_on, 0);
        check("lrst_pix_x_cleared", pix_x, 0);
        @(negedge clk);
        lcd_rst_n = 1'b1;
        run_vec(mk(1'b1, 16'hE004, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0), "lrst_idle_data");
        run_vec(mk(1'b0, 16'h002C, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0), "lrst_ramwr2");
        run_vec(mk(1'b1, 16'hE005, 1'b0, 1'b1, 1, 0, 0, 1'b0, 1'b0), "lrst_origin");

        // ---------------- async reset mid-command ----------------
        run_vec(mk(1'b0, 16'h0029, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1), "arst_dispon");
        run_vec(mk(1'b0, 16'h002A, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1), "arst_caset");
        run_vec(mk(1'b1, 16'h0000, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1), "arst_p0");
        run_vec(mk(1'b1, 16'h0007, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1), "arst_p1");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("arst_display_immediate", display_on, 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(1'b1, 16'h0000, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0), "arst_p2_ignored");
        run_vec(mk(1'b1, 16'h0008, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0), "arst_p3_ignored");
        run_vec(mk(1'b0, 16'h002C, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0), "arst_ramwr");
        run_vec(mk(1'b1, 16'hF001, 1'b0, 1'b1, 1, 0, 0, 1'b0, 1'b0), "arst_pix0");
        run_vec(mk(1'b1, 16'hF002, 1'b0, 1'b1, 1, 1, 0, 1'b0, 1'b0), "arst_pix1");

        // ---------------- randomized back-to-back bursts vs model ----------------
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        for (int b = 0; b < 40; b++) begin
            obs_q.delete();
            exp_q.delete();
            for (int k = 0; k < 8; k++) begin
                g_r  = $urandom_range(0, 99);
                g_cs = (g_r < 6);
                g_rd = !(g_r >= 6 && g_r < 12);
                if ($urandom_range(0, 99) < 30) begin
                    g_rs   = 1'b0;
                    g_code = cmd_list[$urandom_range(0, 9)];
                    if (g_code == 8'h00) g_code = 8'($urandom);
                    g_data = {8'($urandom), g_code};
                end else begin
                    g_rs   = 1'b1;
                    g_data = 16'($urandom);
                    if (m_state == 1 || m_state == 2) begin
                        if (m_par.size() % 2 == 0)
                            g_data[7:0] = ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0;
                        else
                            g_data[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(230, 255))
                                                                      : 8'($urandom_range(0, 12));
                    end
                end
                m_write(g_rs, g_data, g_cs, g_rd);
                write_word(g_rs, g_data, g_cs, g_rd);
            end
            settle();
            check($sformatf("rnd%0d_event_count", b), obs_q.size(), exp_q.size());
            n_cmp = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
            for (int i = 0; i < n_cmp; i++) begin
                check($sformatf("rnd%0d_ev%0d", b, i), obs_q[i], exp_q[i]);
            end
            check($sformatf("rnd%0d_sleep_out", b), sleep_out, m_sleep);
            check($sformatf("rnd%0d_display_on", b), display_on, m_disp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
